mem_1rw_port_arbiter: RTL and testbench

- Upstream front-end for a single-port (1RW) register-file bank.
- Accepts an independent write-request channel and a read-request channel, each with valid/ready handshakes.
- Arbitrates the two channels round-robin onto the bank's single RW port and returns read data through a 1-entry registered response buffer with its own valid/ready handshake.
- Drives the bank's RW0_* port directly. The bank is assumed to have a combinational read (RW0_rdata = array[RW0_addr]) and a masked synchronous write.

---
 rtl/mem_1rw_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_1rw_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_1rw_port_arbiter.sv
// Round-robin write/read front-end for a 1RW bank; requests accepted in the grant cycle, read data 1 cycle later.
// Reads stall while the 1-entry response buffer is full and not draining; writes are never blocked by it.
module mem_1rw_port_arbiter #(
  parameter int REG_DEPTH = 4,
  parameter int REG_WIDTH = 64,
  parameter int CNT_WIDTH = 16,
  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [REG_WIDTH-1:0] wr_wmask,
  input  logic [REG_WIDTH-1:0] wr_wdata,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rd_resp_valid,
  input  logic                 rd_resp_ready,
  output logic [REG_WIDTH-1:0] rd_resp_data,
  output logic                 RW0_wen,
  output logic [AW-1:0]        RW0_addr,
  output logic [REG_WIDTH-1:0] RW0_wmask,
  output logic [REG_WIDTH-1:0] RW0_wdata,
  input  logic [REG_WIDTH-1:0] RW0_rdata,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  typedef enum logic {GRANT_WR, GRANT_RD} grant_e;
  typedef enum logic {RESP_EMPTY, RESP_FULL} resp_e;

  grant_e               last_grant;
  resp_e                resp_state;
  logic [REG_WIDTH-1:0] resp_data;
  logic                 can_rd;
  logic                 grant_wr;
  logic                 grant_rd;
  logic                 conflict;

  // A full buffer that is draining this cycle can be refilled in the same cycle.
  assign can_rd   = rd_req_valid && ((resp_state == RESP_EMPTY) || rd_resp_ready);
  assign conflict = wr_valid && can_rd;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (reset) begin
      if (conflict) begin
        grant_wr = (last_grant == GRANT_RD);
        grant_rd = (last_grant == GRANT_WR);
      end else begin
        grant_wr = wr_valid;
        grant_rd = can_rd;
      end
    end
  end

  assign wr_ready      = grant_wr;
  assign rd_req_ready  = grant_rd;
  assign rd_resp_valid = (resp_state == RESP_FULL);
  assign rd_resp_data  = resp_data;

  // Write fields are zeroed when idle so the bank never sees stale write data.
  always_comb begin
    RW0_wen   = grant_wr;
    RW0_addr  = rd_addr;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (grant_wr) begin
      RW0_addr  = wr_addr;
      RW0_wmask = wr_wmask;
      RW0_wdata = wr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant   <= GRANT_WR;
      resp_state   <= RESP_EMPTY;
      resp_data    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant_rd) begin
        resp_data  <= RW0_rdata;
        resp_state <= RESP_FULL;
      end else if (rd_resp_ready && (resp_state == RESP_FULL)) begin
        resp_state <= RESP_EMPTY;
      end

      if (grant_wr) begin
        last_grant <= GRANT_WR;
      end else if (grant_rd) begin
        last_grant <= GRANT_RD;
      end

      if (conflict && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_1rw_port_arbiter.sv
// Bench for mem_1rw_port_arbiter with a behavioural 1RW bank and a read-data scoreboard.
module tb_mem_1rw_port_arbiter;

  localparam int W  = 64;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_wmask;
  logic [W-1:0]  wr_wdata;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_resp_valid;
  logic          rd_resp_ready;
  logic [W-1:0]  rd_resp_data;
  logic          rw0_wen;
  logic [AW-1:0] rw0_addr;
  logic [W-1:0]  rw0_wmask;
  logic [W-1:0]  rw0_wdata;
  logic [W-1:0]  rw0_rdata;
  logic [15:0]   conflict_cnt;

  logic          s_wr_ready;
  logic          s_rd_req_ready;
  logic          s_rd_resp_valid;
  logic [W-1:0]  s_rd_resp_data;
  logic          s_wen;
  logic [AW-1:0] s_addr;
  logic [W-1:0]  s_wmask;
  logic [W-1:0]  s_wdata;
  logic [3:0]    s_conflict_cnt;

  logic [W-1:0]  bank    [4];
  logic [W-1:0]  ref_mem [4];
  logic [W-1:0]  sb_q    [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_1rw_port_arbiter #(.REG_DEPTH(4), .REG_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_wmask(wr_wmask), .wr_wdata(wr_wdata),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .RW0_wen(rw0_wen), .RW0_addr(rw0_addr), .RW0_wmask(rw0_wmask),
    .RW0_wdata(rw0_wdata), .RW0_rdata(rw0_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance sharing stimulus; only its counter is observed.
  mem_1rw_port_arbiter #(.REG_DEPTH(4), .REG_WIDTH(W), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(s_wr_ready), .wr_addr(wr_addr),
    .wr_wmask(wr_wmask), .wr_wdata(wr_wdata),
    .rd_req_valid(rd_req_valid), .rd_req_ready(s_rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(s_rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(s_rd_resp_data),
    .RW0_wen(s_wen), .RW0_addr(s_addr), .RW0_wmask(s_wmask),
    .RW0_wdata(s_wdata), .RW0_rdata(rw0_rdata),
    .conflict_cnt(s_conflict_cnt)
  );

  assign rw0_rdata = bank[rw0_addr];

  always @(posedge clk) begin
    if (rw0_wen) bank[rw0_addr] <= (bank[rw0_addr] & ~rw0_wmask) | (rw0_wdata & rw0_wmask);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expected);
    n_checks++;
    if (obs === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expected);
  endtask

  // Scoreboard: reference memory updated on accepted writes, expected data queued on accepted reads.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (!reset) begin
      sb_q.delete();
    end else begin
      if (rd_resp_valid && rd_resp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_resp", {63'd0, rd_resp_valid}, '0);
        end else begin
          exp_v = sb_q.pop_front();
          check("sb_data", rd_resp_data, exp_v);
        end
      end
      if (rd_req_valid && rd_req_ready) sb_q.push_back(ref_mem[rd_addr]);
      if (wr_valid && wr_ready)
        ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_wmask) | (wr_wdata & wr_wmask);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid      = 1'b0;
    wr_addr       = '0;
    wr_wmask      = '0;
    wr_wdata      = '0;
    rd_req_valid  = 1'b0;
    rd_addr       = '0;
    rd_resp_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    step();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic drive_contention(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_valid      = 1'b1;
    wr_addr       = a;
    wr_wmask      = '1;
    wr_wdata      = d;
    rd_req_valid  = 1'b1;
    rd_addr       = a;
    rd_resp_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      bank[i]    = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b0;
    idle();
    wr_valid     = 1'b1;
    wr_addr      = 2'd1;
    wr_wmask     = '1;
    rd_req_valid = 1'b1;
    sample();
    check("rst_resp_valid", {63'd0, rd_resp_valid}, 64'd0);
    check("rst_resp_data", rd_resp_data, 64'd0);
    check("rst_cnt", {48'd0, conflict_cnt}, 64'd0);
    check("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("rst_rd_ready", {63'd0, rd_req_ready}, 64'd0);
    check("rst_wen", {63'd0, rw0_wen}, 64'd0);
    step();
    reset = 1'b1;
    idle();

    // Full-mask write then read-back
    step();
    wr_valid = 1'b1; wr_addr = 2'd2; wr_wmask = '1; wr_wdata = 64'hDEADBEEF_CAFEF00D;
    sample();
    check("wr_ready", {63'd0, wr_ready}, 64'd1);
    check("wr_wen", {63'd0, rw0_wen}, 64'd1);
    check("wr_addr", {62'd0, rw0_addr}, 64'd2);
    step();
    idle(); rd_req_valid = 1'b1; rd_addr = 2'd2;
    sample();
    check("rd_ready", {63'd0, rd_req_ready}, 64'd1);
    step();
    idle();
    sample();
    check("rd_valid", {63'd0, rd_resp_valid}, 64'd1);
    check("rd_data", rd_resp_data, 64'hDEADBEEF_CAFEF00D);

    // Partial mask
    step();
    wr_valid = 1'b1; wr_addr = 2'd1; wr_wmask = '1; wr_wdata = '1;
    sample();
    step();
    wr_wmask = 64'h0000_0000_FFFF_FFFF; wr_wdata = '0;
    sample();
    check("pm_wmask", rw0_wmask, 64'h0000_0000_FFFF_FFFF);
    check("pm_wdata", rw0_wdata, 64'd0);
    step();
    idle(); rd_req_valid = 1'b1; rd_addr = 2'd1;
    sample();
    step();
    idle();
    sample();
    check("pm_data", rd_resp_data, 64'hFFFFFFFF_00000000);

    // Continuous contention from reset
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive_contention(2'd3, 64'h100 + 64'(i));
      sample();
      check("cont_rd_grant", {63'd0, rd_req_ready}, {63'd0, (i % 2) == 0});
      check("cont_wr_grant", {63'd0, wr_ready}, {63'd0, (i % 2) == 1});
      step();
    end
    idle();
    sample();
    check("cont_cnt", {48'd0, conflict_cnt}, 64'd6);

    // Backpressure with a pending read and concurrent writes
    step();
    rd_req_valid = 1'b1; rd_addr = 2'd2;
    sample();
    check("bp_first_grant", {63'd0, rd_req_ready}, 64'd1);
    step();
    rd_addr = 2'd1; rd_resp_ready = 1'b0;
    wr_valid = 1'b1; wr_addr = 2'd0; wr_wmask = '1; wr_wdata = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("bp_rd_ready", {63'd0, rd_req_ready}, 64'd0);
      check("bp_wr_ready", {63'd0, wr_ready}, 64'd1);
      check("bp_valid", {63'd0, rd_resp_valid}, 64'd1);
      check("bp_data_hold", rd_resp_data, 64'hDEADBEEF_CAFEF00D);
      check("bp_cnt", {48'd0, conflict_cnt}, 64'd6);
      step();
    end
    wr_valid = 1'b0; rd_resp_ready = 1'b1;
    sample();
    check("bp_release_grant", {63'd0, rd_req_ready}, 64'd1);
    step();
    idle();
    sample();
    check("bp_new_valid", {63'd0, rd_resp_valid}, 64'd1);
    check("bp_new_data", rd_resp_data, 64'hFFFFFFFF_00000000);

    // Reset with a response pending and a write presented
    step();
    rd_req_valid = 1'b1; rd_addr = 2'd2; rd_resp_ready = 1'b0;
    sample();
    step();
    rd_req_valid = 1'b0;
    reset = 1'b0;
    wr_valid = 1'b1; wr_addr = 2'd0; wr_wmask = '1; wr_wdata = 64'hBAD;
    sample();
    check("mr_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("mr_wen", {63'd0, rw0_wen}, 64'd0);
    step();
    reset = 1'b1;
    idle();
    sample();
    check("mr_valid", {63'd0, rd_resp_valid}, 64'd0);
    check("mr_cnt", {48'd0, conflict_cnt}, 64'd0);
    step();
    drive_contention(2'd0, 64'hBAD);
    sample();
    check("mr_first_rd", {63'd0, rd_req_ready}, 64'd1);
    check("mr_first_wr", {63'd0, wr_ready}, 64'd0);
    step();
    sample();
    check("mr_second_wr", {63'd0, wr_ready}, 64'd1);
    check("mr_old_data", rd_resp_data, 64'h1111_2222_3333_4444);
    step();
    idle();
    sample();

    // Saturation of the narrow counter
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive_contention(2'd3, 64'h200 + 64'(i));
      sample();
      check("sat_cnt", {60'd0, s_conflict_cnt}, (i < 15) ? 64'(i) : 64'd15);
      step();
    end
    idle();
    sample();
    check("sat_final", {60'd0, s_conflict_cnt}, 64'd15);
    check("wide_cnt", {48'd0, conflict_cnt}, 64'd20);
    step();
    sample();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
